// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch flush.
// Define STALL_STATS_EN to add the stall_count / flush_count cycle counters.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_I_type,
    input  logic               id_branch,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic               ex_branch_taken,
    output logic               id_ex_valid,
    output logic [4:0]         id_ex_rs,
    output logic [4:0]         id_ex_rt,
    output logic [4:0]         id_ex_rd,
    output logic               id_ex_regwrite,
    output logic               id_ex_memread,
    output logic               id_ex_memwrite,
    output logic               I_type,
    output logic               branch,
    output logic [ALUOP_W-1:0] id_ex_aluop,
    output logic [DATA_W-1:0]  id_ex_rs_data,
    output logic [DATA_W-1:0]  id_ex_rt_data,
    output logic [DATA_W-1:0]  id_ex_imm,
    output logic [DATA_W-1:0]  id_ex_pc,
    output logic               stall_if_id,
    output logic               flush_if_id
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count
`endif
);

    typedef enum logic {RUN, LU_STALL} state_t;

    typedef struct packed {
        logic               valid;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         rd;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               iType;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  rsData;
        logic [DATA_W-1:0]  rtData;
        logic [DATA_W-1:0]  imm;
        logic [DATA_W-1:0]  pc;
    } idex_t;

    state_t state_q, state_d;
    idex_t  idex_q, idex_d, captured;
    logic   loadUse, stall, flush;

    always_comb begin
        loadUse = id_valid && idex_q.valid && idex_q.memread && (idex_q.rd != 5'd0) &&
                  ((idex_q.rd == id_rs) || (!id_I_type && (idex_q.rd == id_rt)));
    end

    // Reset masks stall/flush combinationally so they drop in the reset cycle itself.
    always_comb begin
        flush    = ex_branch_taken && !rst;
        stall    = loadUse && (state_q == RUN) && !ex_branch_taken && !rst;
        captured = '0;
        if (id_valid) begin
            captured.valid    = 1'b1;
            captured.rs       = id_rs;
            captured.rt       = id_rt;
            captured.rd       = id_rd;
            captured.regwrite = id_regwrite && (id_rd != 5'd0);
            captured.memread  = id_memread;
            captured.memwrite = id_memwrite;
            captured.iType    = id_I_type;
            captured.branch   = id_branch;
            captured.aluop    = id_aluop;
            captured.rsData   = id_rs_data;
            captured.rtData   = id_rt_data;
            captured.imm      = id_imm;
            captured.pc       = id_pc;
        end
        state_d = RUN;
        idex_d  = captured;
        if (flush) begin
            idex_d = '0;
        end else if (stall) begin
            idex_d  = '0;
            state_d = LU_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            idex_q  <= '0;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

`ifdef STALL_STATS_EN
    logic [31:0] stallCount_q, flushCount_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount_q <= '0;
            flushCount_q <= '0;
        end else begin
            if (stall) stallCount_q <= stallCount_q + 32'd1;
            if (flush) flushCount_q <= flushCount_q + 32'd1;
        end
    end

    assign stall_count = stallCount_q;
    assign flush_count = flushCount_q;
`endif

    assign id_ex_valid    = idex_q.valid;
    assign id_ex_rs       = idex_q.rs;
    assign id_ex_rt       = idex_q.rt;
    assign id_ex_rd       = idex_q.rd;
    assign id_ex_regwrite = idex_q.regwrite;
    assign id_ex_memread  = idex_q.memread;
    assign id_ex_memwrite = idex_q.memwrite;
    assign I_type         = idex_q.iType;
    assign branch         = idex_q.branch;
    assign id_ex_aluop    = idex_q.aluop;
    assign id_ex_rs_data  = idex_q.rsData;
    assign id_ex_rt_data  = idex_q.rtData;
    assign id_ex_imm      = idex_q.imm;
    assign id_ex_pc       = idex_q.pc;
    assign stall_if_id    = stall;
    assign flush_if_id    = flush;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand sequences, random run.
// Counter checks are compiled in when STALL_STATS_EN is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_regwrite, id_memread, id_memwrite, id_I_type, id_branch;
    logic [3:0]  id_aluop;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc;
    logic        ex_branch_taken;
    logic        id_ex_valid;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite, exIType, exBranch;
    logic [3:0]  id_ex_aluop;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_pc;
    logic        stall_if_id, flush_if_id;
`ifdef STALL_STATS_EN
    logic [31:0] stall_count, flush_count;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_I_type(id_I_type), .id_branch(id_branch), .id_aluop(id_aluop),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc(id_pc),
        .ex_branch_taken(ex_branch_taken),
        .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .id_ex_memwrite(id_ex_memwrite), .I_type(exIType), .branch(exBranch),
        .id_ex_aluop(id_ex_aluop), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
        .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id)
`ifdef STALL_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, mw, it, br;
        logic [3:0]  aluop;
        logic [31:0] rsd, rtd, imm, pc;
    } rec_t;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, rd;
        logic       rw, mr, it, bt;
        logic       eStall, eFlush, eValid;
        logic [4:0] eRs, eRd;
        logic       eRw, eMr;
    } vec_t;

    // Reference model: the instruction that should sit in ID/EX, and whether the
    // previous cycle was a load-use stall (a stall may never repeat back-to-back).
    rec_t mRec;
    bit   mStalledLast;
    int   mStalls, mFlushes;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic rw, input logic mr,
                                 input logic it, input logic bt);
        id_valid        = v;
        id_rs           = rs;
        id_rt           = rt;
        id_rd           = rd;
        id_regwrite     = rw;
        id_memread      = mr;
        id_I_type       = it;
        ex_branch_taken = bt;
        id_memwrite     = 1'($urandom_range(0, 1));
        id_branch       = 1'($urandom_range(0, 1));
        id_aluop        = 4'($urandom_range(0, 15));
        id_rs_data      = $urandom;
        id_rt_data      = $urandom;
        id_imm          = $urandom;
        id_pc           = $urandom;
    endtask

    task automatic checkOutput();
        chk("id_ex_valid",    32'(id_ex_valid),    32'(mRec.valid));
        chk("id_ex_rs",       32'(id_ex_rs),       32'(mRec.rs));
        chk("id_ex_rt",       32'(id_ex_rt),       32'(mRec.rt));
        chk("id_ex_rd",       32'(id_ex_rd),       32'(mRec.rd));
        chk("id_ex_regwrite", 32'(id_ex_regwrite), 32'(mRec.rw));
        chk("id_ex_memread",  32'(id_ex_memread),  32'(mRec.mr));
        chk("id_ex_memwrite", 32'(id_ex_memwrite), 32'(mRec.mw));
        chk("I_type",         32'(exIType),        32'(mRec.it));
        chk("branch",         32'(exBranch),       32'(mRec.br));
        chk("id_ex_aluop",    32'(id_ex_aluop),    32'(mRec.aluop));
        chk("id_ex_rs_data",  id_ex_rs_data,       mRec.rsd);
        chk("id_ex_rt_data",  id_ex_rt_data,       mRec.rtd);
        chk("id_ex_imm",      id_ex_imm,           mRec.imm);
        chk("id_ex_pc",       id_ex_pc,            mRec.pc);
`ifdef STALL_STATS_EN
        chk("stall_count",    stall_count,         32'(mStalls));
        chk("flush_count",    flush_count,         32'(mFlushes));
`endif
    endtask

    // One clock: check stall/flush before the edge, advance the model, check registers after.
    task automatic runCycle(output logic gotStall, output logic gotFlush);
        bit hazard, eStall, eFlush;
        #1;
        hazard = !rst && id_valid && mRec.valid && mRec.mr && (mRec.rd != 0) &&
                 ((mRec.rd == id_rs) || (!id_I_type && (mRec.rd == id_rt)));
        eFlush = !rst && ex_branch_taken;
        eStall = hazard && !eFlush && !mStalledLast;
        gotStall = stall_if_id;
        gotFlush = flush_if_id;
        chk("stall_if_id", 32'(stall_if_id), 32'(eStall));
        chk("flush_if_id", 32'(flush_if_id), 32'(eFlush));
        @(posedge clk);
        if (rst) begin
            mRec = '0;
            mStalledLast = 0;
            mStalls = 0;
            mFlushes = 0;
        end else begin
            if (eStall) mStalls++;
            if (eFlush) mFlushes++;
            if (eFlush || eStall || !id_valid) mRec = '0;
            else mRec = '{1'b1, id_rs, id_rt, id_rd, id_regwrite && (id_rd != 0), id_memread,
                          id_memwrite, id_I_type, id_branch, id_aluop,
                          id_rs_data, id_rt_data, id_imm, id_pc};
            mStalledLast = eStall;
        end
        #1;
        checkOutput();
    endtask

    initial begin
        logic s, f;
        mRec = '0;
        mStalledLast = 0;
        mStalls = 0;
        mFlushes = 0;

        vecs[0]  = '{1, 1, 2, 8,  1, 1, 1, 0,  0, 0, 1, 1, 8,  1, 1};
        vecs[1]  = '{1, 8, 3, 9,  1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0};
        vecs[2]  = '{1, 8, 3, 9,  1, 0, 0, 0,  0, 0, 1, 8, 9,  1, 0};
        vecs[3]  = '{1, 4, 6, 8,  1, 1, 1, 0,  0, 0, 1, 4, 8,  1, 1};
        vecs[4]  = '{1, 5, 8, 10, 1, 0, 1, 0,  0, 0, 1, 5, 10, 1, 0};
        vecs[5]  = '{1, 1, 2, 0,  1, 1, 1, 0,  0, 0, 1, 1, 0,  0, 1};
        vecs[6]  = '{1, 0, 0, 0,  1, 0, 0, 0,  0, 0, 1, 0, 0,  0, 0};
        vecs[7]  = '{1, 2, 3, 8,  1, 1, 1, 0,  0, 0, 1, 2, 8,  1, 1};
        vecs[8]  = '{1, 8, 3, 9,  1, 0, 0, 1,  0, 1, 0, 0, 0,  0, 0};
        vecs[9]  = '{1, 8, 3, 9,  1, 0, 0, 0,  0, 0, 1, 8, 9,  1, 0};
        vecs[10] = '{0, 8, 8, 8,  1, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0};
        vecs[11] = '{1, 3, 4, 7,  1, 1, 1, 0,  0, 0, 1, 3, 7,  1, 1};
        vecs[12] = '{1, 7, 1, 11, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0};
        vecs[13] = '{1, 7, 1, 11, 1, 0, 0, 1,  0, 1, 0, 0, 0,  0, 0};
        vecs[14] = '{1, 7, 1, 11, 1, 0, 0, 0,  0, 0, 1, 7, 11, 1, 0};
        vecs[15] = '{1, 1, 2, 6,  1, 1, 1, 0,  0, 0, 1, 1, 6,  1, 1};
        vecs[16] = '{1, 2, 6, 12, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0};
        vecs[17] = '{1, 2, 6, 12, 1, 0, 0, 0,  0, 0, 1, 2, 12, 1, 0};

        // Reset with every input held high.
        rst = 1'b1;
        applyStimulus(1, 5'h1f, 5'h1f, 5'h1f, 1, 1, 1, 1);
        id_memwrite = 1'b1; id_branch = 1'b1; id_aluop = 4'hf;
        id_rs_data = '1; id_rt_data = '1; id_imm = '1; id_pc = '1;
        for (int i = 0; i < 2; i++) begin
            runCycle(s, f);
            chk("reset stall", 32'(s), 32'd0);
            chk("reset flush", 32'(f), 32'd0);
            chk("reset valid", 32'(id_ex_valid), 32'd0);
            chk("reset pc", id_ex_pc, 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                          vecs[i].rw, vecs[i].mr, vecs[i].it, vecs[i].bt);
            runCycle(s, f);
            chk($sformatf("vec%0d stall", i), 32'(s), 32'(vecs[i].eStall));
            chk($sformatf("vec%0d flush", i), 32'(f), 32'(vecs[i].eFlush));
            chk($sformatf("vec%0d valid", i), 32'(id_ex_valid), 32'(vecs[i].eValid));
            chk($sformatf("vec%0d rs", i), 32'(id_ex_rs), 32'(vecs[i].eRs));
            chk($sformatf("vec%0d rd", i), 32'(id_ex_rd), 32'(vecs[i].eRd));
            chk($sformatf("vec%0d regwrite", i), 32'(id_ex_regwrite), 32'(vecs[i].eRw));
            chk($sformatf("vec%0d memread", i), 32'(id_ex_memread), 32'(vecs[i].eMr));
        end
`ifdef STALL_STATS_EN
        chk("table stall_count", stall_count, 32'd3);
        chk("table flush_count", flush_count, 32'd2);
`endif

        // Reset arriving while a load-use hazard is present drops the stall immediately.
        applyStimulus(1, 1, 2, 8, 1, 1, 1, 0);
        runCycle(s, f);
        applyStimulus(1, 8, 3, 9, 1, 0, 0, 0);
        #1;
        chk("pre-reset stall", 32'(stall_if_id), 32'd1);
        rst = 1'b1;
        runCycle(s, f);
        chk("mid-stall reset stall", 32'(s), 32'd0);
        chk("mid-stall reset valid", 32'(id_ex_valid), 32'd0);
`ifdef STALL_STATS_EN
        chk("reset stall_count", stall_count, 32'd0);
        chk("reset flush_count", flush_count, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            applyStimulus($urandom_range(0, 7) != 0, 5'($urandom_range(0, 9)),
                          5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            runCycle(s, f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
